// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: WIDTH-bit registered bitwise logic unit with eight ops and a 2-entry output FIFO.
// Optional macro LOGIC_GATE_PIPE_PARITY_EN adds a per-entry parity bit on port y_par.
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
`ifdef LOGIC_GATE_PIPE_PARITY_EN
    output logic             y_par,
`endif
    output logic [CNT_W-1:0] txn_count
);
`ifdef LOGIC_GATE_PIPE_PARITY_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif
    logic [WIDTH-1:0] res;
    logic [EW-1:0]    res_e, e0_q, e0_d, e1_q, e1_d;
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] txn_q;
    logic             push, pop;

    always_comb begin
        res = a;
        case (op)
            3'b000: res = ~a;
            3'b001: res = a & b;
            3'b010: res = a | b;
            3'b011: res = a ^ b;
            3'b100: res = ~(a & b);
            3'b101: res = ~(a | b);
            3'b110: res = ~(a ^ b);
            3'b111: res = a;
        endcase
    end

`ifdef LOGIC_GATE_PIPE_PARITY_EN
    assign res_e = {^res, res};
    assign y_par = out_valid & e0_q[WIDTH];
`else
    assign res_e = res;
`endif

    // in_ready comes from the registered count only; rst masks it so nothing is accepted during reset
    assign in_ready  = ~count_q[1] & ~rst;
    assign out_valid = count_q != 2'd0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign y         = e0_q[WIDTH-1:0];
    assign zero      = out_valid & ~|y;
    assign txn_count = txn_q;

    always_comb begin
        e0_d    = (push && (count_q == 2'd0 || (count_q == 2'd1 && pop))) ? res_e :
                  (pop && count_q == 2'd2) ? e1_q : e0_q;
        e1_d    = (push && count_q == 2'd1 && !pop) ? res_e : e1_q;
        count_d = count_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= '0;
            txn_q   <= '0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
            txn_q   <= txn_q + CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb_logic_gate_pipe: scoreboard bench; driver queues expected results, negedge monitor pops and compares.
module tb_logic_gate_pipe;
    logic       clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic       in_ready, out_valid, zero;
    logic [7:0] a = 0, b = 0, y;
    logic [2:0] op = 0;
    logic [3:0] txn_count;
`ifdef LOGIC_GATE_PIPE_PARITY_EN
    logic       y_par;
`endif
    logic [7:0] q[$];
    logic [3:0] exp_txn = 0;
    int         checks = 0, failures = 0;

    logic_gate_pipe #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero),
`ifdef LOGIC_GATE_PIPE_PARITY_EN
        .y_par(y_par),
`endif
        .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got y=%0h with empty scoreboard at %0t", y, $time);
            end else begin
                logic [7:0] ey;
                ey = q.pop_front();
                chk("y", y, ey);
                chk("zero", zero, ey == 8'h00);
`ifdef LOGIC_GATE_PIPE_PARITY_EN
                chk("y_par", y_par, ^ey);
`endif
                exp_txn++;
            end
        end
    end

    task automatic send(input logic [7:0] ta, tb, input logic [2:0] top, input logic [7:0] ey);
        int n = 0;
        a = ta; b = tb; op = top; in_valid = 1;
        while (1) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(ey);
                break;
            end
            if (++n > 50) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: in_ready=0 expected 1 within 50 cycles");
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1;
        while ((q.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_done", n < 50, 1);
    endtask

    logic [7:0] sw_exp [8] = '{8'h0F, 8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_zero", zero, 0);
        chk("rst_txn", txn_count, 0);
        rst = 0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1;
        send(8'hA5, 8'h00, 3'b000, 8'h5A);
        chk("latency_out_valid", out_valid, 1);
        @(posedge clk); #1;
        chk("txn_after_first", txn_count, 1);
        for (int i = 0; i < 8; i++) send(8'hF0, 8'hCC, 3'(i), sw_exp[i]);
        drain();
        chk("txn_after_sweep", txn_count, 9);
        send(8'hFF, 8'hFF, 3'b011, 8'h00);
        send(8'h01, 8'h00, 3'b111, 8'h01);
        drain();
        out_ready = 0;
        send(8'h01, 8'h00, 3'b000, 8'hFE);
        send(8'h02, 8'h00, 3'b000, 8'hFD);
        chk("full_in_ready", in_ready, 0);
        fork
            send(8'h03, 8'h00, 3'b000, 8'hFC);
        join_none
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_y_hold", y, 8'hFE);
        end
        @(posedge clk); #1;
        out_ready = 1;
        wait fork;
        drain();
        chk("txn_after_stall", txn_count, 4'd14);
        out_ready = 0;
        send(8'h10, 8'h00, 3'b000, 8'hEF);
        out_ready = 1;
        send(8'h20, 8'h00, 3'b000, 8'hDF);
        chk("pushpop_out_valid", out_valid, 1);
        chk("pushpop_head", y, 8'hDF);
        drain();
        chk("txn_after_pushpop", txn_count, 4'd0);
        for (int i = 0; i < 20 && exp_txn != 4'd15; i++) begin
            send(8'(i), 8'h00, 3'b111, 8'(i));
            drain();
        end
        chk("txn_at_max", txn_count, 4'd15);
        send(8'h77, 8'h00, 3'b111, 8'h77);
        drain();
        chk("txn_wrap", txn_count, 4'd0);
        out_ready = 0;
        send(8'hAA, 8'h55, 3'b001, 8'h00);
        send(8'hAA, 8'h55, 3'b010, 8'hFF);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_out_valid", out_valid, 1);
        rst = 1; in_valid = 1; out_ready = 1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_y", y, 0);
        chk("midrst_zero", zero, 0);
        chk("midrst_txn", txn_count, 0);
`ifdef LOGIC_GATE_PIPE_PARITY_EN
        chk("midrst_y_par", y_par, 0);
`endif
        rst = 0; in_valid = 0; out_ready = 0;
        q.delete();
        exp_txn = 0;
        #1;
        chk("after_rst_in_ready", in_ready, 1);
        send(8'h00, 8'h00, 3'b000, 8'hFF);
        drain();
        chk("txn_after_reset_use", txn_count, 1);
        chk("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/logic_gate_pipe.md
Name: logic_gate_pipe

Overview:
- Parametrised, registered successor to the single-bit inverter: a WIDTH-bit bitwise logic unit with eight runtime-selectable operations, including NOT.
- Operands enter through a valid/ready input port. Results leave through a 2-entry output buffer with its own valid/ready port.
- in_ready depends only on registered state, so downstream stalls never create a combinational path back to the producer.
- Sits between switch/register sources and display/datapath consumers on the board-level design.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- CNT_W, 16, width of the completed-transaction counter (>=1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored for NOT and BUF.
- op  input  3  operation select, sampled at input handshake.
- out_valid  output  1  y and zero hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- y  output  WIDTH  result at the buffer head.
- zero  output  1  high when out_valid=1 and y is all zeros.
- txn_count  output  CNT_W  number of completed output handshakes.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high, sampled only on the rising clk edge.
- Reset values: buffer count=0, out_valid=0, y=0, zero=0, txn_count=0. in_ready=0 while rst=1 and 1 in the first cycle after rst falls.
- Opcode map:
  - 000 NOT: ~a
  - 001 AND: a&b
  - 010 OR: a|b
  - 011 XOR: a^b
  - 100 NAND: ~(a&b)
  - 101 NOR: ~(a|b)
  - 110 XNOR: ~(a^b)
  - 111 BUF: a
  - All operations are bitwise over WIDTH bits; no carries, no sign handling.
- Input handshake: accept occurs when in_valid && in_ready at a rising edge. The result is computed from a, b and op at that edge and written to the buffer tail.
- No input transfer when in_valid=0; a, b and op are don't-care.
- Buffer: 2-entry FIFO with a 2-bit count, strictly in order.
  - out_valid = (count != 0).
  - y and zero are taken from the head entry.
  - in_ready = (count < 2), registered.
- Latency: with the buffer empty, a result accepted at edge N appears with out_valid=1 in the cycle after edge N (1 cycle).
- Output handshake: pop occurs when out_valid && out_ready. y must be held stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop:
  - count=1: count stays 1 and the new result becomes the head after the edge.
  - count=0: push only; pop is impossible.
  - count=2: push is impossible (in_ready=0), so pop only.
- txn_count increments by 1 on every output handshake. It wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-operation: rst=1 at any edge discards all buffered results and restores every reset value. No handshake is honoured on an edge where rst=1.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
- Macro: LOGIC_GATE_PIPE_PARITY_EN.
- When defined:
  - Extra output port y_par (1 bit) = XOR-reduction of the head entry's y, stored per buffer entry alongside the result.
  - y_par = 0 when out_valid=0 and on reset.
- When undefined: port y_par and its storage are absent. All other behaviour is identical.

Test Plan:
- Reset, then a=8'hA5, op=000, out_ready=1 -> y=8'h5A one cycle after accept, zero=0, txn_count=1.
- Sweep all ops with a=8'hF0, b=8'hCC. Required y per op:
  - 000 -> 0F
  - 001 -> C0
  - 010 -> FC
  - 011 -> 3C
  - 100 -> 3F
  - 101 -> 03
  - 110 -> C3
  - 111 -> F0
- a=8'hFF, b=8'hFF, op=011 -> y=8'h00, zero=1; with PARITY_EN, y_par=0. Separately, a=8'h01, op=111 -> y_par=1.
- Hold out_ready=0 and push three requests back to back (NOT of 8'h01, 8'h02, 8'h03):
  - in_ready falls after the 2nd accept; the 3rd is held off.
  - y holds 8'hFE while stalled.
  - Releasing out_ready yields FE, FD, FC in order; txn_count=3.
- With count=1, drive a push and a pop on the same edge -> count stays 1, out_valid stays 1, the new result appears at the head, and no result is lost or duplicated.
- Fill the buffer to 2 entries, assert rst for one cycle -> out_valid=0, y=0, txn_count=0, in_ready=0 during reset and 1 the cycle after. Also force txn_count=CNT_W max via 2^CNT_W pops with CNT_W=4 -> wraps from 15 to 0.
